wb_dest_queue: RTL
==================

Name: wb_dest_queue

Overview:
- Successor to the write-register selector of the multicycle CPU.
- Selects the destination register from rt, rd, the link register or "none", using the same 2-bit Regout code.
- Queues each selected destination in order from issue to writeback, so several instructions can be in flight.
- Drives the register-file write address at writeback and flags a read-after-write hazard when a source register matches any pending destination.

Parameters:
- REG_AW, 5: register address width.
- DEPTH, 4: number of in-flight destinations; any value >= 2.
- LINK_REG, 31: destination used when Regout = 2'b10.

Ports:
- CLK  in  1  clock; all state updates on the rising edge.
- Reset  in  1  synchronous, active-high reset.
- rt  in  REG_AW  instruction rt field.
- rd  in  REG_AW  instruction rd field.
- Regout  in  2  destination select: 00 = rt, 01 = rd, 10 = LINK_REG, 11 = none (register 0).
- issue  in  1  push the currently selected destination.
- wb  in  1  writeback done; pop the head entry.
- rs_chk  in  REG_AW  source register 1 to hazard-check.
- rt_chk  in  REG_AW  source register 2 to hazard-check.
- sel_dest  out  REG_AW  combinational selected destination.
- wb_dest  out  REG_AW  head entry's destination; 0 when empty.
- wb_valid  out  1  queue non-empty.
- count  out  $clog2(DEPTH+1)  number of valid entries.
- full  out  1  count == DEPTH.
- empty  out  1  count == 0.
- hazard  out  1  combinational RAW hit.
- err  out  1  sticky overflow/underflow flag.

Behaviour:
- sel_dest decodes purely combinationally from Regout, rt and rd, including during Reset.
  - Regout = 11 gives 0.
  - LINK_REG is truncated to REG_AW bits.
- Storage is a circular buffer with DEPTH entries, a write pointer, a read pointer and a count.
  - Pointers wrap from DEPTH-1 to 0; DEPTH need not be a power of 2.
- Reset, taking priority over everything and valid mid-operation:
  - Pointers, count and err cleared; every entry's valid bit cleared.
  - Outputs after reset: empty = 1, full = 0, wb_valid = 0, wb_dest = 0, count = 0, err = 0, hazard = 0.
- Push: issue = 1 and not full writes sel_dest into slot[wptr], sets its valid bit, advances wptr, and increments count.
- Pop: wb = 1 and not empty clears slot[rptr]'s valid bit, advances rptr, and decrements count.
- Issue and wb in the same cycle with 0 < count < DEPTH: both happen and count is unchanged.
- Issue and wb in the same cycle when full: both accepted, since the pop frees a slot in the same edge; count stays DEPTH and err is not set.
- issue when full without wb: the push is dropped, state is unchanged, and err is set.
- wb when empty: the pop is ignored and err is set.
  - If issue is also high in that cycle, the push still happens, so count goes to 1 and err is set. There is no bypass path.
- err stays at 1 until Reset.
- wb_dest and wb_valid reflect the registered head entry and update one edge after the push or pop that changes it. Latency from issue to wb_valid on an empty queue is 1 cycle.
- hazard = 1 when some valid entry has dest != 0 and dest equals rs_chk or rt_chk.
  - Evaluated against pre-edge state: an entry being popped in the current cycle still counts.
  - An entry being pushed in the current cycle does not count until the next cycle.
  - Entries with dest = 0 are queued, to keep writeback ordering, but never raise hazard.
- count and the full/empty flags are registered values derived from state, never from same-cycle inputs.

Test Plan:
- Reset, then Regout = 00/01/10/11 with rt = 3, rd = 1 -> sel_dest = 3, 1, 31, 0 each cycle with no clock dependence; wb_dest = 0 and empty = 1 throughout.
- Issue rd = 5, 6, 7, 8 (Regout = 01) on consecutive cycles -> count goes 1, 2, 3, 4; full = 1 after the 4th edge. Then wb ×4 -> wb_dest = 5, 6, 7, 8 in order, and empty = 1 after the last edge.
- Fill the queue to full, then assert issue and wb together with rd = 9 -> count stays 4, err = 0; subsequent pops give 6, 7, 8, 9, which confirms the pointer wrap.
- Full queue with issue alone -> count stays 4 and err = 1. wb on an empty queue -> err stays 1; Reset -> err = 0.
- Pending dests {0, 12}, rs_chk = 12 -> hazard = 1; rs_chk = 0, rt_chk = 0 -> hazard = 0; pop 12 with rs_chk = 12 held -> hazard = 1 during the pop cycle and 0 the next cycle.
- Assert Reset with 3 entries pending -> next cycle count = 0, wb_valid = 0, hazard = 0 for any check value.

Source files
------------

// File: rtl/wb_dest_queue.sv
// Destination-register selector with an in-order issue-to-writeback queue.
// Drives the writeback address and flags RAW hazards against pending destinations.
module wb_dest_queue #(
    parameter int REG_AW   = 5,
    parameter int DEPTH    = 4,
    parameter int LINK_REG = 31
) (
    input  logic                           CLK,
    input  logic                           Reset,
    input  logic [REG_AW-1:0]              rt,
    input  logic [REG_AW-1:0]              rd,
    input  logic [1:0]                     Regout,
    input  logic                           issue,
    input  logic                           wb,
    input  logic [REG_AW-1:0]              rs_chk,
    input  logic [REG_AW-1:0]              rt_chk,
    output logic [REG_AW-1:0]              sel_dest,
    output logic [REG_AW-1:0]              wb_dest,
    output logic                           wb_valid,
    output logic [$clog2(DEPTH+1)-1:0]     count,
    output logic                           full,
    output logic                           empty,
    output logic                           hazard,
    output logic                           err
);

    localparam int CW = $clog2(DEPTH + 1);
    localparam int PW = $clog2(DEPTH);
    localparam logic [CW-1:0]     DEPTH_C   = CW'(DEPTH);
    localparam logic [PW-1:0]     LAST_PTR  = PW'(DEPTH - 1);
    localparam logic [REG_AW-1:0] LINK_DEST = REG_AW'(LINK_REG);

    logic [REG_AW-1:0] dest_q [DEPTH];
    logic [DEPTH-1:0]  valid_q;
    logic [PW-1:0]     wptr_q, wptr_d;
    logic [PW-1:0]     rptr_q, rptr_d;
    logic [CW-1:0]     count_q, count_d;
    logic              err_q, err_d;
    logic              do_push, do_pop;
    logic [DEPTH-1:0]  hit;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == LAST_PTR) ? '0 : p + 1'b1;
    endfunction

    always_comb begin
        sel_dest = '0;
        case (Regout)
            2'b00:   sel_dest = rt;
            2'b01:   sel_dest = rd;
            2'b10:   sel_dest = LINK_DEST;
            default: sel_dest = '0;
        endcase
    end

    // A pop on a full queue frees the slot the push lands in on the same edge.
    assign do_pop  = wb && (count_q != '0);
    assign do_push = issue && ((count_q != DEPTH_C) || do_pop);

    always_comb begin
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        count_d = count_q;
        err_d   = err_q;
        if (do_push) begin
            wptr_d = ptr_inc(wptr_q);
        end
        if (do_pop) begin
            rptr_d = ptr_inc(rptr_q);
        end
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
        if ((issue && !do_push) || (wb && !do_pop)) begin
            err_d = 1'b1;
        end
    end

    always_ff @(posedge CLK) begin
        if (Reset) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
            err_q   <= 1'b0;
            valid_q <= '0;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            count_q <= count_d;
            err_q   <= err_d;
            for (int i = 0; i < DEPTH; i++) begin
                // Push wins when both hit the same slot (full queue, pop + push).
                if (do_push && (wptr_q == PW'(i))) begin
                    valid_q[i] <= 1'b1;
                end else if (do_pop && (rptr_q == PW'(i))) begin
                    valid_q[i] <= 1'b0;
                end
            end
        end
    end

    always_ff @(posedge CLK) begin
        for (int i = 0; i < DEPTH; i++) begin
            if (!Reset && do_push && (wptr_q == PW'(i))) begin
                dest_q[i] <= sel_dest;
            end
        end
    end

    // Register 0 entries keep writeback order but never constitute a hazard.
    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_hit
            assign hit[gi] = valid_q[gi] && (dest_q[gi] != '0) &&
                             ((dest_q[gi] == rs_chk) || (dest_q[gi] == rt_chk));
        end
    endgenerate

    assign hazard   = |hit;
    assign wb_valid = valid_q[rptr_q];
    assign wb_dest  = valid_q[rptr_q] ? dest_q[rptr_q] : '0;
    assign count    = count_q;
    assign full     = (count_q == DEPTH_C);
    assign empty    = (count_q == '0);
    assign err      = err_q;

endmodule
